programmable_timeout_counter: RTL and testbench
===============================================

PROGRAMMABLE_TIMEOUT_COUNTER -- requirements
Module: programmable_timeout_counter

Interface
REQ-001 Parameter WIDTH, default 7: bit width of the count and terminal value.
REQ-002 Parameter DEFAULT_TERM, default 99: terminal value used when term input is 0.
REQ-003 Parameter PRESCALE_W, default 4: prescaler width; used only with PTC_PRESCALE_EN.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cnt_en  in  1  count enable; low pauses RUN and re-arms from DONE.
REQ-007 term  in  WIDTH  terminal count; 0 selects DEFAULT_TERM.
REQ-008 mode  in  1  0 = one-shot, 1 = auto-reload.
REQ-009 clear  in  1  synchronous abort to IDLE.
REQ-010 prescale  in  PRESCALE_W  tick divider, cycles-per-tick minus 1; port present only with PTC_PRESCALE_EN.
REQ-011 timeout  out  1  single-cycle pulse at each terminal count.
REQ-012 done  out  1  level, one-shot finished.
REQ-013 busy  out  1  high in RUN.
REQ-014 count  out  WIDTH  current count value.

Function
REQ-015 States IDLE, RUN, DONE; state, count, term_q and outputs are registered.
REQ-016 tick = cnt_en in RUN (qualified by prescaler when compiled in).
REQ-017 IDLE, cnt_en=1: -> RUN; term_q <= (term==0 ? DEFAULT_TERM : term); count <= 0.
REQ-018 RUN, tick, count != term_q: count <= count+1; timeout <= 0.
REQ-019 RUN, tick, count == term_q: timeout <= 1 for one cycle; count <= 0; mode=1 stays RUN and reloads term_q from term (0 -> DEFAULT_TERM); mode=0 -> DONE.
REQ-020 RUN, cnt_en=0: count and prescaler hold; no timeout; state stays RUN.
REQ-021 term changes during RUN ignored until next load (IDLE entry or auto-reload).
REQ-022 DONE: done=1, busy=0, count=0; cnt_en=0 -> IDLE; cnt_en held 1 stays DONE (no retrigger).
REQ-023 mode sampled only at terminal count; change mid-run takes effect at that tick.
REQ-024 Period: terminal value T gives T+1 ticks per timeout; first timeout high in cycle after edge E+T+1, E = IDLE-exit edge (no prescaler).
REQ-025 count never exceeds term_q; no wrap beyond 2^WIDTH-1; term=2^WIDTH-1 legal.
REQ-026 clear=1 (priority over all but reset): state IDLE, count 0, timeout 0, done 0, prescaler 0.
REQ-027 clear and terminal tick on same edge: clear wins, no timeout pulse.
REQ-028 busy = (state==RUN); done = (state==DONE); both registered-state decodes.

Reset
REQ-029 rst=0 asynchronously forces IDLE, count=0, term_q=0, prescaler=0, timeout=0, done=0, busy=0.
REQ-030 Reset deassertion synchronous to clk; first edge after release may leave IDLE if cnt_en=1.
REQ-031 Reset mid-RUN discards progress; no timeout pulse on or after reset.

Configuration
REQ-032 PTC_PRESCALE_EN defined: prescale port and PRESCALE_W-bit prescaler compiled in; in RUN with cnt_en=1 prescaler counts 0..prescale, tick asserted on the cycle it equals prescale then it returns to 0; prescaler resets on RUN entry, reload, clear, reset; prescale=0 gives tick every enabled cycle.
REQ-033 PTC_PRESCALE_EN undefined: no prescale port, no prescaler logic; tick = cnt_en in RUN.

Verification
REQ-034 Defaults, term=0, mode=0, cnt_en held 1 -> count ramps 0..99, one timeout pulse after edge E+100, done=1, busy=0, no further pulses.
REQ-035 term=5, mode=1, cnt_en held 1 -> timeout pulses every 6 cycles; term changed to 2 mid-period -> next period 6, following periods 3.
REQ-036 term=10, mode=0, cnt_en dropped 4 cycles at count=3 -> count holds at 3, timeout delayed exactly 4 cycles; drop from DONE -> IDLE, re-raise restarts.
REQ-037 rst=0 asynchronously at count=7 and clear=1 coincident with terminal tick -> outputs zero immediately / no timeout pulse, state IDLE.
REQ-038 PTC_PRESCALE_EN, prescale=3, term=4, mode=1 -> timeout every 20 cycles; build without macro -> every 5 cycles.
REQ-039 WIDTH=4, term=15, mode=1 -> count reaches 15, returns to 0, never overflows; pulse every 16 cycles.

Source files
------------

// File: rtl/programmable_timeout_counter.sv
// Programmable timeout counter: IDLE/RUN/DONE sequencer with one-shot or auto-reload terminal pulses.
// Optional tick prescaler compiled in with `define PTC_PRESCALE_EN.
module programmable_timeout_counter #(
  parameter int WIDTH        = 7,
  parameter int DEFAULT_TERM = 99,
  parameter int PRESCALE_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cnt_en,
  input  logic [WIDTH-1:0]      term,
  input  logic                  mode,
  input  logic                  clear,
`ifdef PTC_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic                  timeout,
  output logic                  done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEF_TERM = WIDTH'(DEFAULT_TERM);

  state_t           state_r, state_n_s;
  logic [WIDTH-1:0] count_r, count_n_s;
  logic [WIDTH-1:0] term_q_r, term_q_n_s;
  logic [WIDTH-1:0] eff_term_s;
  logic             timeout_r, timeout_n_s;
  logic             done_r, busy_r;
  logic             tick_s;

  assign eff_term_s = (term == ZERO) ? DEF_TERM : term;

`ifdef PTC_PRESCALE_EN
  localparam logic [PRESCALE_W-1:0] PZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PONE  = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] presc_r;

  assign tick_s = (state_r == ST_RUN) && cnt_en && (presc_r == prescale);

  // Prescaler: held at zero outside RUN, so RUN entry and reload always start from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r <= PZERO;
    end else if (clear || (state_r != ST_RUN)) begin
      presc_r <= PZERO;
    end else if (cnt_en) begin
      presc_r <= (presc_r == prescale) ? PZERO : (presc_r + PONE);
    end else begin
      presc_r <= presc_r;
    end
  end
`else
  assign tick_s = (state_r == ST_RUN) && cnt_en;
`endif

  // Next-state, count and terminal-pulse decode; clear overrides everything except reset.
  always_comb begin
    state_n_s   = state_r;
    count_n_s   = count_r;
    term_q_n_s  = term_q_r;
    timeout_n_s = 1'b0;
    if (clear) begin
      state_n_s = ST_IDLE;
      count_n_s = ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          count_n_s = ZERO;
          if (cnt_en) begin
            state_n_s  = ST_RUN;
            term_q_n_s = eff_term_s;
          end else begin
            state_n_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (tick_s) begin
            if (count_r == term_q_r) begin
              timeout_n_s = 1'b1;
              count_n_s   = ZERO;
              // mode only matters here, at the terminal tick
              if (mode) begin
                term_q_n_s = eff_term_s;
              end else begin
                state_n_s = ST_DONE;
              end
            end else begin
              count_n_s = count_r + ONE;
            end
          end else begin
            count_n_s = count_r;
          end
        end
        ST_DONE: begin
          count_n_s = ZERO;
          if (!cnt_en) begin
            state_n_s = ST_IDLE;
          end else begin
            state_n_s = ST_DONE;
          end
        end
        default: begin
          state_n_s = ST_IDLE;
          count_n_s = ZERO;
        end
      endcase
    end
  end

  // State, count, terminal latch and registered output flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      count_r   <= ZERO;
      term_q_r  <= ZERO;
      timeout_r <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      count_r   <= count_n_s;
      term_q_r  <= term_q_n_s;
      timeout_r <= timeout_n_s;
      done_r    <= (state_n_s == ST_DONE);
      busy_r    <= (state_n_s == ST_RUN);
    end
  end

  assign timeout = timeout_r;
  assign done    = done_r;
  assign busy    = busy_r;
  assign count   = count_r;

endmodule

// File: tb/tb_programmable_timeout_counter.sv
// Scoreboard bench for programmable_timeout_counter (default build, WIDTH=7, DEFAULT_TERM=99).
module tb_programmable_timeout_counter;

  logic       clk;
  logic       rst;
  logic       cnt_en;
  logic [6:0] term;
  logic       mode;
  logic       clear;
  logic       timeout;
  logic       done;
  logic       busy;
  logic [6:0] count;

  int total;
  int bad;
  int cyc;
  int exp_q[$];
  int exp_v;
  int e;

  programmable_timeout_counter dut (
    .clk     (clk),
    .rst     (rst),
    .cnt_en  (cnt_en),
    .term    (term),
    .mode    (mode),
    .clear   (clear),
    .timeout (timeout),
    .done    (done),
    .busy    (busy),
    .count   (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every timeout pulse must match the next expected cycle in the queue.
  always @(negedge clk) begin
    if (timeout) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL timeout_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        exp_v = exp_q.pop_front();
        if (exp_v != cyc) begin
          bad = bad + 1;
          $display("FAIL timeout_cycle: pulse at cycle %0d, expected cycle %0d", cyc, exp_v);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    total = total + 1;
    if (act != expv) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic go(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic start(input int t, input logic m, output int edge_e);
    term   = 7'(t);
    mode   = m;
    cnt_en = 1'b1;
    edge_e = cyc + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total  = 0;
    bad    = 0;
    cyc    = 0;
    rst    = 1'b0;
    cnt_en = 1'b0;
    term   = 7'd0;
    mode   = 1'b0;
    clear  = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;
    @(negedge clk);

    // Default terminal 99, one-shot
    start(0, 1'b0, e);
    exp_q.push_back(e + 100);
    go(e);
    check("t1_busy", int'(busy), 1);
    check("t1_count0", int'(count), 0);
    go(e + 99);
    check("t1_count99", int'(count), 99);
    go(e + 101);
    check("t1_done", int'(done), 1);
    check("t1_busy_off", int'(busy), 0);
    check("t1_count_done", int'(count), 0);
    go(e + 120);
    check("t1_done_held", int'(done), 1);
    cnt_en = 1'b0;
    go(e + 121);
    check("t1_idle_done", int'(done), 0);

    // Auto-reload, term change mid-period, mode switch at terminal
    @(negedge clk);
    start(5, 1'b1, e);
    exp_q.push_back(e + 6);
    exp_q.push_back(e + 12);
    exp_q.push_back(e + 15);
    exp_q.push_back(e + 18);
    go(e + 8);
    term = 7'd2;
    go(e + 16);
    mode = 1'b0;
    go(e + 20);
    check("t2_done", int'(done), 1);
    check("t2_busy", int'(busy), 0);
    cnt_en = 1'b0;
    go(e + 21);
    check("t2_idle_done", int'(done), 0);

    // Pause at count 3 for 4 cycles, then DONE -> IDLE -> restart
    @(negedge clk);
    start(10, 1'b0, e);
    exp_q.push_back(e + 15);
    go(e + 3);
    check("t3_count3", int'(count), 3);
    cnt_en = 1'b0;
    go(e + 5);
    check("t3_hold", int'(count), 3);
    check("t3_busy_hold", int'(busy), 1);
    go(e + 7);
    cnt_en = 1'b1;
    go(e + 17);
    check("t3_done", int'(done), 1);
    cnt_en = 1'b0;
    go(e + 18);
    check("t3_idle", int'(done), 0);
    start(10, 1'b0, e);
    exp_q.push_back(e + 11);
    go(e + 1);
    check("t3_restart_count", int'(count), 1);
    go(e + 13);
    check("t3_done2", int'(done), 1);
    cnt_en = 1'b0;
    go(e + 14);

    // Asynchronous reset mid-run
    start(10, 1'b0, e);
    go(e + 7);
    check("t4_count7", int'(count), 7);
    #2 rst = 1'b0;
    #1;
    check("t4_rst_count", int'(count), 0);
    check("t4_rst_busy", int'(busy), 0);
    check("t4_rst_timeout", int'(timeout), 0);
    cnt_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    go(cyc + 2);
    check("t4_after_busy", int'(busy), 0);

    // Clear coincident with terminal tick
    start(3, 1'b1, e);
    go(e + 3);
    check("t5_count3", int'(count), 3);
    clear = 1'b1;
    go(e + 4);
    check("t5_timeout", int'(timeout), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_count", int'(count), 0);
    clear  = 1'b0;
    cnt_en = 1'b0;
    go(e + 6);
    check("t5_idle_busy", int'(busy), 0);

    // Max terminal, auto-reload, no overflow
    start(127, 1'b1, e);
    exp_q.push_back(e + 128);
    exp_q.push_back(e + 256);
    go(e + 127);
    check("t6_count127", int'(count), 127);
    go(e + 128);
    check("t6_wrap0", int'(count), 0);
    check("t6_busy", int'(busy), 1);
    go(e + 257);
    clear = 1'b1;
    go(e + 258);
    clear  = 1'b0;
    cnt_en = 1'b0;
    go(e + 260);
    check("t6_cleared_busy", int'(busy), 0);

    go(cyc + 5);
    check("pending_expected", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
